// File: rtl/uart_interface_if.sv
// Handler-side byte handshake between uart_interface and the PC interface handler.
// The slave modport is the UART side, the master modport is the handler side.
interface uart_interface_if;
    logic       o_pc_valid;
    logic [7:0] o_pc_data;
    logic       i_pc_rd;
    logic       o_pc_rdy;
    logic [7:0] i_pc_data;
    logic       i_pc_wr;

    modport slave (
        output o_pc_valid, o_pc_data, o_pc_rdy,
        input  i_pc_rd, i_pc_data, i_pc_wr
    );

    modport master (
        input  o_pc_valid, o_pc_data, o_pc_rdy,
        output i_pc_rd, i_pc_data, i_pc_wr
    );
endinterface

// File: rtl/uart_interface.sv
// UART transceiver with RX/TX byte FIFOs facing the PC interface handler.
// Frames are 8N1; defining UART_PARITY_EN switches both directions to 8E1.
module uart_interface_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_push,
    input  logic [7:0]              i_data,
    input  logic                    i_pop,
    output logic [7:0]              o_head,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: memory is cleared in reset so the head byte is defined before the first push.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

module uart_interface #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int RX_FIFO_DEPTH = 8,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rxd,
    output logic             o_txd,
    uart_interface_if.slave  pc,
    output logic             o_frame_err,
    output logic             o_rx_overflow,
    output logic             o_parity_err,
    output logic             o_tx_busy
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int RX_CW = $clog2(RX_FIFO_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LP_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LP_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

    // ---------------- RX path ----------------
    logic             r_rxd_meta, r_rxd_sync;
    rx_state_t        r_rx_state, w_rx_state_next;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_next;
    logic [2:0]       r_rx_bit, w_rx_bit_next;
    logic [7:0]       r_rx_shift, w_rx_shift_next;
    logic             r_frame_err, r_rx_overflow;
    logic             w_frame_err, w_rx_overflow, w_parity_err;
    logic             w_rx_push, w_rx_pop, w_rx_can_push;
    logic [RX_CW-1:0] w_rx_count;
`ifdef UART_PARITY_EN
    logic             r_rx_par_bad, w_rx_par_bad_next;
    logic             r_parity_err;
`endif

    assign w_rx_pop      = pc.i_pc_rd && (w_rx_count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still take the byte.
    assign w_rx_can_push = (w_rx_count != RX_CW'(RX_FIFO_DEPTH)) || w_rx_pop;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt + 1'b1;
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_push       = 1'b0;
        w_frame_err     = 1'b0;
        w_rx_overflow   = 1'b0;
        w_parity_err    = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par_bad_next = r_rx_par_bad;
`endif
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_next = '0;
                w_rx_bit_next = '0;
                if (!r_rxd_sync) w_rx_state_next = RX_START;
            end
            RX_START: if (r_rx_cnt == LP_HALF_END) begin
                w_rx_cnt_next   = '0;
                w_rx_state_next = r_rxd_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (r_rx_cnt == LP_BIT_END) begin
                w_rx_cnt_next   = '0;
                w_rx_shift_next = {r_rxd_sync, r_rx_shift[7:1]};
                w_rx_bit_next   = r_rx_bit + 1'b1;
`ifdef UART_PARITY_EN
                if (r_rx_bit == 3'd7) w_rx_state_next = RX_PARITY;
`else
                if (r_rx_bit == 3'd7) w_rx_state_next = RX_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (r_rx_cnt == LP_BIT_END) begin
                w_rx_cnt_next     = '0;
                w_rx_par_bad_next = (^r_rx_shift) ^ r_rxd_sync;
                w_rx_state_next   = RX_STOP;
            end
`endif
            RX_STOP: if (r_rx_cnt == LP_BIT_END) begin
                w_rx_cnt_next   = '0;
                w_rx_state_next = RX_IDLE;
                if (!r_rxd_sync)        w_frame_err   = 1'b1;
`ifdef UART_PARITY_EN
                else if (r_rx_par_bad)  w_parity_err  = 1'b1;
`endif
                else if (w_rx_can_push) w_rx_push     = 1'b1;
                else                    w_rx_overflow = 1'b1;
            end
            default: w_rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rxd_meta    <= 1'b1;
            r_rxd_sync    <= 1'b1;
            r_rx_state    <= RX_IDLE;
            r_rx_cnt      <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_frame_err   <= 1'b0;
            r_rx_overflow <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_bad  <= 1'b0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            r_rxd_meta    <= i_rxd;
            r_rxd_sync    <= r_rxd_meta;
            r_rx_state    <= w_rx_state_next;
            r_rx_cnt      <= w_rx_cnt_next;
            r_rx_bit      <= w_rx_bit_next;
            r_rx_shift    <= w_rx_shift_next;
            r_frame_err   <= w_frame_err;
            r_rx_overflow <= w_rx_overflow;
`ifdef UART_PARITY_EN
            r_rx_par_bad  <= w_rx_par_bad_next;
            r_parity_err  <= w_parity_err;
`endif
        end
    end

    uart_interface_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_head  (pc.o_pc_data),
        .o_count (w_rx_count)
    );

    assign pc.o_pc_valid = (w_rx_count != '0);
    assign o_frame_err   = r_frame_err;
    assign o_rx_overflow = r_rx_overflow;
`ifdef UART_PARITY_EN
    assign o_parity_err  = r_parity_err;
`else
    assign o_parity_err  = 1'b0;
`endif

    // ---------------- TX path ----------------
    tx_state_t        r_tx_state, w_tx_state_next;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_next;
    logic [2:0]       r_tx_bit, w_tx_bit_next;
    logic [7:0]       r_tx_byte, w_tx_byte_next;
    logic             r_txd, w_txd_next;
    logic             r_pc_rdy;
    logic             w_tx_push, w_tx_pop;
    logic [7:0]       w_tx_head;
    logic [TX_CW-1:0] w_tx_count, w_tx_count_next;

    assign w_tx_push       = pc.i_pc_wr && r_pc_rdy;
    assign w_tx_count_next = w_tx_count + TX_CW'(w_tx_push) - TX_CW'(w_tx_pop);

    // o_txd is registered, so each branch sets the level for the bit that starts at this edge.
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt + 1'b1;
        w_tx_bit_next   = r_tx_bit;
        w_tx_byte_next  = r_tx_byte;
        w_txd_next      = r_txd;
        w_tx_pop        = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_next = '0;
                w_tx_bit_next = '0;
                w_txd_next    = 1'b1;
                if (w_tx_count != '0) begin
                    w_tx_pop        = 1'b1;
                    w_tx_byte_next  = w_tx_head;
                    w_txd_next      = 1'b0;
                    w_tx_state_next = TX_START;
                end
            end
            TX_START: if (r_tx_cnt == LP_BIT_END) begin
                w_tx_cnt_next   = '0;
                w_txd_next      = r_tx_byte[0];
                w_tx_state_next = TX_DATA;
            end
            TX_DATA: if (r_tx_cnt == LP_BIT_END) begin
                w_tx_cnt_next = '0;
                if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                    w_txd_next      = ^r_tx_byte;
                    w_tx_state_next = TX_PARITY;
`else
                    w_txd_next      = 1'b1;
                    w_tx_state_next = TX_STOP;
`endif
                end else begin
                    w_tx_bit_next = r_tx_bit + 1'b1;
                    w_txd_next    = r_tx_byte[r_tx_bit + 3'd1];
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (r_tx_cnt == LP_BIT_END) begin
                w_tx_cnt_next   = '0;
                w_txd_next      = 1'b1;
                w_tx_state_next = TX_STOP;
            end
`endif
            TX_STOP: if (r_tx_cnt == LP_BIT_END) begin
                w_tx_cnt_next   = '0;
                w_txd_next      = 1'b1;
                w_tx_state_next = TX_IDLE;
            end
            default: w_tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
            r_txd      <= 1'b1;
            r_pc_rdy   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_byte  <= w_tx_byte_next;
            r_txd      <= w_txd_next;
            r_pc_rdy   <= (w_tx_count_next != TX_CW'(TX_FIFO_DEPTH));
        end
    end

    uart_interface_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_tx_push),
        .i_data  (pc.i_pc_data),
        .i_pop   (w_tx_pop),
        .o_head  (w_tx_head),
        .o_count (w_tx_count)
    );

    assign pc.o_pc_rdy = r_pc_rdy;
    assign o_txd       = r_txd;
    assign o_tx_busy   = (r_tx_state != TX_IDLE);
endmodule

// File: tb/tb_uart_interface.sv
// Self-checking bench for uart_interface (8N1 build, CLKS_PER_BIT=16, FIFO depths 4).
// RX frames come from a vector table; TX, overflow, glitch and reset use directed sequences.
module tb_uart_interface;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    // Sync (2) + idle detect (1) + half start bit + 8 data bits + stop bit.
    localparam int RX_LATENCY = 2 + 1 + CPB / 2 + 8 * CPB + CPB;

    logic clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_rxd = 1'b1;
    logic o_txd, o_frame_err, o_rx_overflow, o_parity_err, o_tx_busy;

    uart_interface_if pc_if ();

    uart_interface #(
        .CLKS_PER_BIT  (CPB),
        .RX_FIFO_DEPTH (DEPTH),
        .TX_FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_rxd         (i_rxd),
        .o_txd         (o_txd),
        .pc            (pc_if),
        .o_frame_err   (o_frame_err),
        .o_rx_overflow (o_rx_overflow),
        .o_parity_err  (o_parity_err),
        .o_tx_busy     (o_tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_ferr   = 0;
    int n_ovf    = 0;
    int n_perr   = 0;
    int cyc      = 0;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_frame_err)   n_ferr++;
        if (o_rx_overflow) n_ovf++;
        if (o_parity_err)  n_perr++;
        if (pc_if.o_pc_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = pc_if.o_pc_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called and returns on a negedge; each bit is held for CPB cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        i_rxd = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            i_rxd = d[i];
            idle(CPB);
        end
        i_rxd = stop;
        idle(CPB);
        i_rxd = 1'b1;
    endtask

    task automatic pop_byte(input string name, input logic [7:0] exp);
        check(name, 32'(pc_if.o_pc_data), 32'(exp));
        pc_if.i_pc_rd = 1'b1;
        @(negedge clk);
        pc_if.i_pc_rd = 1'b0;
    endtask

    // o_txd must hold v for every one of the next len cycles.
    task automatic expect_level(input string name, input logic v, input int len);
        logic bad;
        bad = 1'b0;
        repeat (len) begin
            if (o_txd !== v) bad = 1'b1;
            @(negedge clk);
        end
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic expect_tx_frame(input string tag, input logic [7:0] d);
        expect_level($sformatf("%s start", tag), 1'b0, CPB);
        for (int i = 0; i < 8; i++)
            expect_level($sformatf("%s bit%0d", tag, i), d[i], CPB);
        expect_level($sformatf("%s stop", tag), 1'b1, CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        int         exp_ferr;
    } rx_vec_t;

    rx_vec_t rx_tab[6];

    initial begin
        int f0, o0, p0, bad_idle, t0;
        logic found;

        rx_tab[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0};
        rx_tab[1] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1};
        rx_tab[2] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0};
        rx_tab[3] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0};
        rx_tab[4] = '{data: 8'h81, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1};
        rx_tab[5] = '{data: 8'h5A, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 0};

        pc_if.i_pc_rd   = 1'b0;
        pc_if.i_pc_wr   = 1'b0;
        pc_if.i_pc_data = 8'h00;

        // Reset values and a quiet idle period.
        idle(3);
        i_rst = 1'b0;
        check("reset txd",   32'(o_txd), 32'd1);
        check("reset valid", 32'(pc_if.o_pc_valid), 32'd0);
        check("reset data",  32'(pc_if.o_pc_data), 32'h00);
        check("reset rdy",   32'(pc_if.o_pc_rdy), 32'd1);
        check("reset busy",  32'(o_tx_busy), 32'd0);
        bad_idle = 0;
        repeat (100) begin
            if (o_txd !== 1'b1 || pc_if.o_pc_valid !== 1'b0 || o_tx_busy !== 1'b0) bad_idle++;
            @(negedge clk);
        end
        check("idle outputs", 32'(bad_idle), 32'd0);
        check("idle pulses",  32'(n_ferr + n_ovf + n_perr), 32'd0);

        // Exact RX latency: valid appears the cycle after the stop sample.
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(5);
        check("rx latency", 32'(rise_cyc - t0), 32'(RX_LATENCY));
        check("rx latency valid", 32'(pc_if.o_pc_valid), 32'd1);
        pop_byte("rx latency data", 8'hA5);
        check("rx latency valid after rd", 32'(pc_if.o_pc_valid), 32'd0);

        // Table-driven RX frames.
        for (int v = 0; v < 6; v++) begin
            f0 = n_ferr;
            send_frame(rx_tab[v].data, rx_tab[v].stop);
            idle(20);
            check($sformatf("vec%0d valid", v), 32'(pc_if.o_pc_valid), 32'(rx_tab[v].exp_valid));
            check($sformatf("vec%0d frame_err", v), 32'(n_ferr - f0), 32'(rx_tab[v].exp_ferr));
            if (rx_tab[v].exp_valid) begin
                pop_byte($sformatf("vec%0d data", v), rx_tab[v].data);
                check($sformatf("vec%0d valid after rd", v), 32'(pc_if.o_pc_valid), 32'd0);
            end
        end

        // Five back-to-back frames into a 4-deep FIFO.
        o0 = n_ovf;
        f0 = n_ferr;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(20);
        check("ovf pulses", 32'(n_ovf - o0), 32'd1);
        check("ovf no frame_err", 32'(n_ferr - f0), 32'd0);
        check("ovf valid", 32'(pc_if.o_pc_valid), 32'd1);
        for (int i = 1; i <= 4; i++) pop_byte($sformatf("ovf rd%0d", i), 8'(i));
        check("ovf drained", 32'(pc_if.o_pc_valid), 32'd0);

        // Short low glitch: no push, no error.
        f0 = n_ferr;
        o0 = n_ovf;
        i_rxd = 1'b0;
        idle(4);
        i_rxd = 1'b1;
        idle(30);
        check("glitch valid", 32'(pc_if.o_pc_valid), 32'd0);
        check("glitch errors", 32'((n_ferr - f0) + (n_ovf - o0)), 32'd0);

        // Two TX writes on consecutive cycles.
        pc_if.i_pc_wr = 1'b1;
        pc_if.i_pc_data = 8'h55;
        check("tx rdy w0", 32'(pc_if.o_pc_rdy), 32'd1);
        @(negedge clk);
        pc_if.i_pc_data = 8'hC3;
        check("tx rdy w1", 32'(pc_if.o_pc_rdy), 32'd1);
        @(negedge clk);
        pc_if.i_pc_wr = 1'b0;
        check("tx rdy after", 32'(pc_if.o_pc_rdy), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_txd === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("tx start seen", 32'(found), 32'd1);
        expect_tx_frame("tx55", 8'h55);
        expect_level("tx gap", 1'b1, 1);
        expect_tx_frame("txC3", 8'hC3);
        check("tx done busy", 32'(o_tx_busy), 32'd0);
        check("tx done txd",  32'(o_txd), 32'd1);

        // Fill the TX FIFO while a frame is in flight, then reset mid-frame.
        pc_if.i_pc_wr = 1'b1;
        pc_if.i_pc_data = 8'h11;
        @(negedge clk);
        pc_if.i_pc_wr = 1'b0;
        idle(2);
        check("fill busy", 32'(o_tx_busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill rdy%0d", i), 32'(pc_if.o_pc_rdy), 32'(i < 4));
            pc_if.i_pc_wr = 1'b1;
            pc_if.i_pc_data = 8'(8'h21 + i);
            @(negedge clk);
        end
        pc_if.i_pc_wr = 1'b0;
        check("fill rdy held", 32'(pc_if.o_pc_rdy), 32'd0);
        check("mid-frame txd", 32'(o_txd), 32'd0);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("rst txd",  32'(o_txd), 32'd1);
        check("rst busy", 32'(o_tx_busy), 32'd0);
        check("rst rdy",  32'(pc_if.o_pc_rdy), 32'd1);
        idle(30);
        check("post-rst busy", 32'(o_tx_busy), 32'd0);
        check("post-rst txd",  32'(o_txd), 32'd1);
        check("parity pulses", 32'(n_perr), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_interface.md
Name: uart_interface

Overview:
- Byte-level UART transceiver that sits directly upstream of the PC interface handler on the test core.
- Deserialises 8N1 frames from the PC into an RX FIFO, which presents first-word-fall-through bytes to the handler using a valid/read-strobe handshake.
- Accepts bytes from the handler into a TX FIFO using a ready/write-strobe handshake, and serialises them back to the PC.
- Single clock domain; only i_rxd is asynchronous.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200). Must be >= 8.
- RX_FIFO_DEPTH, 8: RX FIFO entries. Power of two, >= 2.
- TX_FIFO_DEPTH, 8: TX FIFO entries. Power of two, >= 2.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_rxd  in  1  serial input from PC, asynchronous, idle high
- o_txd  out  1  serial output to PC, idle high
- o_pc_valid  out  1  RX FIFO not empty
- o_pc_data  out  8  RX FIFO head byte (first-word-fall-through)
- i_pc_rd  in  1  pops the RX head byte; one strobe pops one byte
- o_pc_rdy  out  1  TX FIFO not full
- i_pc_data  in  8  byte to transmit
- i_pc_wr  in  1  pushes i_pc_data into the TX FIFO
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_rx_overflow  out  1  one-cycle pulse: received byte dropped because RX FIFO full
- o_parity_err  out  1  one-cycle pulse: parity mismatch (see Optional Feature)
- o_tx_busy  out  1  TX FSM not in TX_IDLE

Behaviour:
- Reset values (all registers, synchronous on i_rst):
  - o_txd=1, o_pc_valid=0, o_pc_data=8'h00, o_pc_rdy=1, all error pulses 0, o_tx_busy=0.
  - Both FIFOs empty; FIFO memory cleared to 0.
  - Both FSMs in their IDLE state; bit and baud counters 0.
- Reset mid-frame: the partial RX/TX frame is abandoned; o_txd returns to 1 the cycle after reset.
- RX input synchronisation: i_rxd passes through a 2-flop synchroniser, initialised to 1. All RX decisions use the synchronised level.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: synchronised level 0 -> RX_START; clear the baud counter.
  - RX_START: at count CLKS_PER_BIT/2-1 (mid start bit):
    - level still 0 -> RX_DATA, counter cleared.
    - level 1 -> glitch, return to RX_IDLE with no output.
  - RX_DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits, then go to RX_STOP.
  - RX_STOP: after CLKS_PER_BIT cycles, sample the stop bit, then return to RX_IDLE in the same transition, so a back-to-back start bit is detected.
    - Stop bit 1 and FIFO not full: push the byte.
    - Stop bit 1 and FIFO full: drop the byte, pulse o_rx_overflow.
    - Stop bit 0: drop the byte, pulse o_frame_err.
- RX FIFO:
  - Push takes effect at the clock edge of the stop sample; o_pc_valid=1 and o_pc_data=byte from the next cycle.
  - o_pc_data always shows the head entry.
  - i_pc_rd with FIFO empty is ignored.
  - Simultaneous push and pop: count unchanged; the push is accepted even when full, because the pop frees the slot.
  - Pointers wrap modulo depth; full/empty derived from a count of width clog2(depth)+1.
- TX FIFO:
  - i_pc_wr with o_pc_rdy=0 is ignored (byte lost).
  - o_pc_rdy is registered and reflects the count after the current edge, so it drops the cycle after the write that fills the FIFO.
  - Simultaneous handler push and FSM pop is allowed.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - TX_IDLE with FIFO not empty: pop the head into the shift register -> TX_START.
  - TX_START: o_txd=0 for CLKS_PER_BIT cycles.
  - TX_DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - TX_STOP: o_txd=1 for CLKS_PER_BIT cycles -> TX_IDLE.
  - Queued bytes therefore have exactly one idle cycle between the stop bit and the next start bit.
- o_txd is driven from a register, so it is glitch-free.

Optional Feature:
- Macro: UART_PARITY_EN
- Defined: frames are 8E1.
  - RX: one even-parity bit is sampled between the data bits and the stop bit (extra RX_PARITY state). On mismatch, the byte is dropped and o_parity_err pulses. If both a parity error and a stop-bit error occur, only o_frame_err pulses.
  - TX: an even-parity bit is inserted after the data bits (extra TX_PARITY state).
- Undefined: frames are 8N1, no parity states exist, and o_parity_err is tied to 0.

Test Plan (CLKS_PER_BIT=16, depths 4):
- Reset, then idle 100 cycles -> o_txd=1, o_pc_valid=0, o_pc_rdy=1, no error pulses.
- Drive frame 8'hA5 on i_rxd -> o_pc_valid=1, o_pc_data=8'hA5 one cycle after the stop sample; a single i_pc_rd -> o_pc_valid=0.
- Send 5 back-to-back frames 8'h01..8'h05 with no reads -> FIFO holds 01..04, o_rx_overflow pulses once on 05; four reads return 01,02,03,04 in order.
- Frame 8'h3C with stop bit 0 -> o_frame_err pulses once, no push. A 4-cycle low glitch on i_rxd -> no push, no error.
- Write 8'h55, 8'hC3 on consecutive cycles -> o_txd shows start,10101010(LSB first),stop, then one idle cycle, then the frame for C3. o_pc_rdy stays 1.
- Write 5 bytes while TX is busy (depth 4) -> o_pc_rdy=0 the cycle after the 4th accepted byte (FIFO full). Assert i_rst mid-transmit -> o_txd=1 and o_tx_busy=0 on the next cycle.
